// File: rtl/sbox_fill_ctrl.sv
// ---------------------------------------------------------------------------
// sbox_fill_ctrl
//
// Builds a 256-entry S-box permutation from a stream of chaotic 8-bit
// samples. A 256-bit "used" bitmap rejects duplicate samples, so whatever
// reaches the S-box write port is always a permutation of 0..255. If the
// chaotic source has not completed the table after MAX_SAMPLES accepted
// samples, a deterministic scan fills the remaining slots with the unused
// values in ascending order.
//
// Optional feature (compile-time macro SBOX_NO_FIXPOINT_EN):
//   when defined, a FILL sample that would land at its own index
//   (v == wr_count[7:0] at acceptance) is rejected as well. The fallback
//   scan ignores this rule so the table always completes.
//
// Ports:
//   clk           in   system clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   start         in   single-cycle request to (re)build the table
//   chaos_valid   in   chaotic sample available
//   chaos_data    in   [7:0] chaotic sample
//   chaos_ready   out  sample taken when chaos_valid && chaos_ready
//   sbox_clr      out  one-cycle pulse: downstream clears index/contents
//   sbox_wr_en    out  S-box write strobe
//   sbox_wr_data  out  [7:0] value to write
//   busy          out  high in CLEAR, FILL and FALLBACK
//   done          out  high in DONE
//   wr_count      out  [8:0] writes issued since start (0..256)
//   reject_count  out  [SCNT_W-1:0] rejected samples since start, saturating
// ---------------------------------------------------------------------------
module sbox_fill_ctrl #(
  parameter int MAX_SAMPLES = 4096,
  parameter int SCNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              chaos_valid,
  input  logic [7:0]        chaos_data,
  output logic              chaos_ready,
  output logic              sbox_clr,
  output logic              sbox_wr_en,
  output logic [7:0]        sbox_wr_data,
  output logic              busy,
  output logic              done,
  output logic [8:0]        wr_count,
  output logic [SCNT_W-1:0] reject_count
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CLEAR    = 3'd1,
    S_FILL     = 3'd2,
    S_FALLBACK = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  localparam logic [SCNT_W-1:0] MAX_CNT   = SCNT_W'(MAX_SAMPLES);
  localparam logic [8:0]        TABLE_LEN = 9'd256;

  state_t              state_q,        state_d;
  logic [255:0]        bitmap_q,       bitmap_d;
  logic [8:0]          wr_count_q,     wr_count_d;
  logic [SCNT_W-1:0]   reject_count_q, reject_count_d;
  logic [SCNT_W-1:0]   scnt_q,         scnt_d;
  logic [7:0]          ptr_q,          ptr_d;
  logic                chaos_ready_q,  chaos_ready_d;
  logic                sbox_clr_q,     sbox_clr_d;
  logic                sbox_wr_en_q,   sbox_wr_en_d;
  logic [7:0]          sbox_wr_data_q, sbox_wr_data_d;
  logic                busy_q,         busy_d;
  logic                done_q,         done_d;

  logic                accept;
  logic                fixpt;

  // A sample is taken only while the registered ready is high, which is
  // only ever true in FILL.
  assign accept = chaos_valid && chaos_ready_q;

  // Fixed-point rejection: wr_count_q already counts every earlier unique
  // acceptance, so its low byte is the index this sample would occupy.
`ifdef SBOX_NO_FIXPOINT_EN
  assign fixpt = (chaos_data == wr_count_q[7:0]);
`else
  assign fixpt = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Next-state / next-output computation
  // -------------------------------------------------------------------------
  always_comb begin
    state_d        = state_q;
    bitmap_d       = bitmap_q;
    wr_count_d     = wr_count_q;
    reject_count_d = reject_count_q;
    scnt_d         = scnt_q;
    ptr_d          = ptr_q;
    sbox_wr_en_d   = 1'b0;
    sbox_wr_data_d = sbox_wr_data_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          // Counters are zeroed on entry so they already read 0 while
          // sbox_clr is high.
          state_d        = S_CLEAR;
          bitmap_d       = '0;
          wr_count_d     = '0;
          reject_count_d = '0;
          scnt_d         = '0;
          ptr_d          = '0;
        end
      end

      S_CLEAR: begin
        state_d = S_FILL;
      end

      S_FILL: begin
        if (accept) begin
          scnt_d = scnt_q + 1'b1;
          if (!bitmap_q[chaos_data] && !fixpt) begin
            bitmap_d[chaos_data] = 1'b1;
            sbox_wr_en_d         = 1'b1;
            sbox_wr_data_d       = chaos_data;
            wr_count_d           = wr_count_q + 1'b1;
          end else if (reject_count_q != '1) begin
            reject_count_d = reject_count_q + 1'b1;
          end
        end
        // Leave only after the write of the final acceptance is on the port,
        // so that write completes while still in FILL.
        if (wr_count_q == TABLE_LEN) begin
          state_d = S_DONE;
        end else if (scnt_q >= MAX_CNT) begin
          state_d = S_FALLBACK;
        end
      end

      S_FALLBACK: begin
        if (wr_count_q == TABLE_LEN) begin
          state_d = S_DONE;
        end else begin
          if (!bitmap_q[ptr_q]) begin
            bitmap_d[ptr_q] = 1'b1;
            sbox_wr_en_d    = 1'b1;
            sbox_wr_data_d  = ptr_q;
            wr_count_d      = wr_count_q + 1'b1;
          end
          ptr_d = ptr_q + 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Registered handshake/status outputs follow the next state, so ready
    // drops on the very edge that accepts the 256th unique sample or the
    // last sample of the budget.
    chaos_ready_d = (state_d == S_FILL) && (wr_count_d < TABLE_LEN) &&
                    (scnt_d < MAX_CNT);
    sbox_clr_d    = (state_d == S_CLEAR);
    busy_d        = (state_d == S_CLEAR) || (state_d == S_FILL) ||
                    (state_d == S_FALLBACK);
    done_d        = (state_d == S_DONE);
  end

  // -------------------------------------------------------------------------
  // State and output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      bitmap_q       <= '0;
      wr_count_q     <= '0;
      reject_count_q <= '0;
      scnt_q         <= '0;
      ptr_q          <= '0;
      chaos_ready_q  <= 1'b0;
      sbox_clr_q     <= 1'b0;
      sbox_wr_en_q   <= 1'b0;
      sbox_wr_data_q <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      bitmap_q       <= bitmap_d;
      wr_count_q     <= wr_count_d;
      reject_count_q <= reject_count_d;
      scnt_q         <= scnt_d;
      ptr_q          <= ptr_d;
      chaos_ready_q  <= chaos_ready_d;
      sbox_clr_q     <= sbox_clr_d;
      sbox_wr_en_q   <= sbox_wr_en_d;
      sbox_wr_data_q <= sbox_wr_data_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
    end
  end

  assign chaos_ready  = chaos_ready_q;
  assign sbox_clr     = sbox_clr_q;
  assign sbox_wr_en   = sbox_wr_en_q;
  assign sbox_wr_data = sbox_wr_data_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign wr_count     = wr_count_q;
  assign reject_count = reject_count_q;

endmodule

// File: tb/tb_sbox_fill_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sbox_fill_ctrl
//
// Directed sequence with randomized sample streams. A reference model turns
// the offered sample list into the expected write sequence (unique values in
// acceptance order, then the unused values ascending if the sample budget
// runs out), the expected reject count and the expected number of accepted
// samples. Macro SBOX_NO_FIXPOINT_EN selects the fixed-point rule in the
// model and enables the fixed-point directed step.
// ---------------------------------------------------------------------------
module tb_sbox_fill_ctrl;

  localparam int MAXS   = 300;
  localparam int SCNT_W = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              chaos_valid;
  logic [7:0]        chaos_data;
  logic              chaos_ready;
  logic              sbox_clr;
  logic              sbox_wr_en;
  logic [7:0]        sbox_wr_data;
  logic              busy;
  logic              done;
  logic [8:0]        wr_count;
  logic [SCNT_W-1:0] reject_count;

  sbox_fill_ctrl #(.MAX_SAMPLES(MAXS), .SCNT_W(SCNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .chaos_valid  (chaos_valid),
    .chaos_data   (chaos_data),
    .chaos_ready  (chaos_ready),
    .sbox_clr     (sbox_clr),
    .sbox_wr_en   (sbox_wr_en),
    .sbox_wr_data (sbox_wr_data),
    .busy         (busy),
    .done         (done),
    .wr_count     (wr_count),
    .reject_count (reject_count)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic [7:0] stim[$];
  logic [7:0] exp_wr[$];
  logic [7:0] wr_log[$];
  int exp_rej, exp_acc;
  int acc_n, last_acc, done_cyc, start_cyc;
  int clr_cnt, clr_cyc, bad_wr;

  // Observer: log writes, clear pulses and any write outside an active build.
  always @(negedge clk) begin
    if (sbox_wr_en) wr_log.push_back(sbox_wr_data);
    if (sbox_clr) begin
      clr_cnt++;
      if (clr_cyc < 0) clr_cyc = cyc;
    end
    if (sbox_wr_en && (!busy || done)) bad_wr++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic flush();
    @(negedge clk);
    step();
  endtask

  task automatic clear_logs();
    wr_log.delete();
    clr_cnt = 0;
    clr_cyc = -1;
    bad_wr  = 0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ready"}, 32'(chaos_ready), 32'h0);
    check({tag, "_clr"},   32'(sbox_clr), 32'h0);
    check({tag, "_wren"},  32'(sbox_wr_en), 32'h0);
    check({tag, "_wrdat"}, 32'(sbox_wr_data), 32'h0);
    check({tag, "_busy"},  32'(busy), 32'h0);
    check({tag, "_done"},  32'(done), 32'h0);
    check({tag, "_wrcnt"}, 32'(wr_count), 32'h0);
    check({tag, "_rej"},   32'(reject_count), 32'h0);
  endtask

  // Reference model: what the table should end up as for the current stim.
  task automatic model();
    bit used[256];
    bit fix;
    int v;
    exp_wr.delete();
    exp_rej = 0;
    exp_acc = 0;
    for (int i = 0; i < 256; i++) used[i] = 1'b0;
    foreach (stim[i]) begin
      if (exp_wr.size() == 256 || exp_acc == MAXS) break;
      exp_acc++;
      v   = int'(stim[i]);
      fix = 1'b0;
`ifdef SBOX_NO_FIXPOINT_EN
      fix = (v == (exp_wr.size() % 256));
`endif
      if (!used[v] && !fix) begin
        used[v] = 1'b1;
        exp_wr.push_back(stim[i]);
      end else begin
        exp_rej++;
      end
    end
    for (int k = 0; k < 256; k++)
      if (!used[k]) exp_wr.push_back(8'(k));
  endtask

  // Offer stim in order, holding each sample until it is taken. Optional
  // start pulses at cycle offsets s0/s1 (-1 = none); stop early once
  // wr_count reaches abort_wr (0 = never) or when done rises.
  task automatic drive(input int pct, input int abort_wr, input int s0,
                       input int s1, input int budget);
    int  k;
    bit  acc;
    k = 0; acc_n = 0; last_acc = -1; done_cyc = -1; start_cyc = -1;
    for (int c = 0; c < budget; c++) begin
      chaos_valid = (k < stim.size()) && ($urandom_range(99) < pct);
      chaos_data  = (k < stim.size()) ? stim[k] : 8'h00;
      start       = (c == s0) || (c == s1);
      if (c == s0) start_cyc = cyc;
      @(negedge clk);
      acc = chaos_valid && chaos_ready;
      if (acc) last_acc = cyc;
      step();
      if (acc) begin k++; acc_n++; end
      start       = 1'b0;
      chaos_valid = 1'b0;
      if (done && done_cyc < 0) begin done_cyc = cyc; break; end
      if (abort_wr > 0 && int'(wr_count) >= abort_wr) break;
    end
    chaos_valid = 1'b0;
    start       = 1'b0;
  endtask

  task automatic check_run(input string tag);
    model();
    check({tag, "_done"},  32'(done), 32'h1);
    check({tag, "_busy"},  32'(busy), 32'h0);
    check({tag, "_ready"}, 32'(chaos_ready), 32'h0);
    check({tag, "_wrcnt"}, 32'(wr_count), 32'd256);
    check({tag, "_rej"},   32'(reject_count), 32'(exp_rej));
    check({tag, "_acc"},   32'(acc_n), 32'(exp_acc));
    check({tag, "_nwr"},   32'(wr_log.size()), 32'd256);
    check({tag, "_clrs"},  32'(clr_cnt), 32'd1);
    check({tag, "_badwr"}, 32'(bad_wr), 32'd0);
    for (int i = 0; i < 256 && i < wr_log.size(); i++)
      check({tag, "_wr", $sformatf("%0d", i)}, 32'(wr_log[i]), 32'(exp_wr[i]));
  endtask

  initial begin
    logic [7:0] perm[256];
    int j;
    logic [7:0] t;

    rst_n = 1'b0; start = 1'b0; chaos_valid = 1'b0; chaos_data = 8'h00;
    clear_logs();

    // Reset state
    repeat (3) step();
    check_idle("rst");
    rst_n = 1'b1;
    step();
    check_idle("rst_rel");

    // Full-rate ordered stream
    stim.delete();
`ifdef SBOX_NO_FIXPOINT_EN
    for (int i = 1; i < 256; i++) stim.push_back(8'(i));
    stim.push_back(8'h00);
`else
    for (int i = 0; i < 256; i++) stim.push_back(8'(i));
`endif
    clear_logs();
    drive(100, 0, 0, -1, 400);
    flush();
    check_run("inord");
    check("inord_done_lat", 32'(done_cyc - last_acc), 32'd2);
    check("inord_clr_cyc",  32'(clr_cyc - start_cyc), 32'd1);

    // Start from DONE: new clear pulse, counters cleared
    clear_logs();
    start = 1'b1;
    step();
    start = 1'b0;
    check("redo_clr",   32'(sbox_clr), 32'h1);
    check("redo_wrcnt", 32'(wr_count), 32'h0);
    check("redo_rej",   32'(reject_count), 32'h0);
    check("redo_busy",  32'(busy), 32'h1);
    check("redo_done",  32'(done), 32'h0);

    // Duplicates 5,5,5,7
    stim = '{8'd5, 8'd5, 8'd5, 8'd7};
    drive(100, 0, -1, -1, 10);
    flush();
    check("dup_nwr",   32'(wr_log.size()), 32'd2);
    if (wr_log.size() >= 2) begin
      check("dup_wr0", 32'(wr_log[0]), 32'd5);
      check("dup_wr1", 32'(wr_log[1]), 32'd7);
    end
    check("dup_rej",   32'(reject_count), 32'd2);
    check("dup_wrcnt", 32'(wr_count), 32'd2);
    check("dup_busy",  32'(busy), 32'd1);

    // Reset mid-operation after 100 writes
    rst_n = 1'b0; step(); rst_n = 1'b1; step();
    stim.delete();
    for (int i = 0; i < 256; i++) stim.push_back(8'(i + 1));
    clear_logs();
    drive(100, 100, 0, -1, 400);
    check("abort_at", 32'(wr_count >= 9'd100), 32'h1);
    #1 rst_n = 1'b0;
    step();
    check_idle("abort");
    clear_logs();
    repeat (5) step();
    check("abort_nowr", 32'(wr_log.size()), 32'd0);
    rst_n = 1'b1;
    step();
    check_idle("abort_rel");

    // Random permutation with injected duplicates, start pulsed while busy
    for (int i = 0; i < 256; i++) perm[i] = 8'(i);
    for (int i = 255; i > 0; i--) begin
      j = $urandom_range(i);
      t = perm[i]; perm[i] = perm[j]; perm[j] = t;
    end
    stim.delete();
    for (int i = 0; i < 256; i++) begin
      stim.push_back(perm[i]);
      if ($urandom_range(7) == 0) stim.push_back(perm[$urandom_range(i)]);
    end
    clear_logs();
    drive(80, 0, 0, 40, 3000);
    flush();
    check_run("perm");

    // Random bytes: budget runs out, fallback completes the table
    stim.delete();
    for (int i = 0; i < 400; i++) stim.push_back(8'($urandom_range(255)));
    clear_logs();
    drive(70, 0, 0, -1, 3000);
    flush();
    check_run("rnd");

    // All samples 0xAA: one write, then fallback scan
    stim.delete();
    for (int i = 0; i < MAXS + 10; i++) stim.push_back(8'hAA);
    clear_logs();
    drive(100, 0, 0, -1, 2000);
    flush();
    check_run("fb");
    check("fb_rej_const", 32'(reject_count), 32'(MAXS - 1));
    if (wr_log.size() == 256) begin
      check("fb_first",  32'(wr_log[0]),   32'hAA);
      check("fb_second", 32'(wr_log[1]),   32'h00);
      check("fb_skip",   32'(wr_log[171]), 32'hAB);
      check("fb_last",   32'(wr_log[255]), 32'hFF);
    end

`ifdef SBOX_NO_FIXPOINT_EN
    // Fixed point at index 0 rejected, next value lands at index 0
    stim = '{8'h00, 8'h01};
    clear_logs();
    drive(100, 0, 0, -1, 10);
    flush();
    check("fix_rej", 32'(reject_count), 32'd1);
    check("fix_nwr", 32'(wr_log.size()), 32'd1);
    if (wr_log.size() >= 1) check("fix_wr0", 32'(wr_log[0]), 32'h01);
    check("fix_wrcnt", 32'(wr_count), 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
